mult_16b_seq: RTL

- Iterative shift-and-add unsigned multiplier, 16x16 -> 32 bits.
- Consumes the sum and carry-out of one 16-bit carry-lookahead adder each cycle, one partial-product add per cycle.
- Sits in the execute stage as the multi-cycle MUL unit.
- Valid/ready handshakes on the input and output sides.

---
 rtl/mul_pkg.sv | 14 +
 rtl/cla_16b.sv | 42 ++++
 rtl/mult_16b_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential MUL unit: default widths and FSM encoding.
package mul_pkg;

    localparam int N_DEF     = 16;
    localparam int CNT_W_DEF = 5;
    localparam int PROD_W    = 2 * N_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/cla_16b.sv
// Carry-lookahead adder built from 4-bit lookahead groups chained on group carry.
module cla_16b #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] c;
    logic [3:0]   gg;
    logic [3:0]   pp;
    logic         cg;

    assign g = a & b;
    assign p = a ^ b;

    // Carries inside a group come straight from the group's incoming carry.
    always_comb begin
        c  = '0;
        gg = '0;
        pp = '0;
        cg = c_in;
        for (int k = 0; k < W / 4; k++) begin
            gg = g[4*k +: 4];
            pp = p[4*k +: 4];
            c[4*k]   = cg;
            c[4*k+1] = gg[0] | (pp[0] & cg);
            c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (&pp[1:0] & cg);
            c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (&pp[2:1] & gg[0]) | (&pp[2:0] & cg);
            cg = gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0])
               | (&pp & cg);
        end
        sum   = p ^ c;
        c_out = cg;
    end

endmodule

// File: rtl/mult_16b_seq.sv
// Iterative shift-and-add unsigned multiplier: one partial-product add per cycle,
// N cycles per product, valid/ready on both sides.
module mult_16b_seq
    import mul_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    state_t         state;
    logic [N-1:0]   mcand;
    logic [N-1:0]   hi;
    logic [N-1:0]   lo;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           c_out;

    assign addend = mcand & {N{lo[0]}};

    cla_16b #(.W(N)) u_cla (
        .a     (hi),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    assign product  = {hi, lo};
    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        lo    <= b;
                        hi    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // 33-bit {c_out, sum, lo} shifted right by one keeps the carry.
                    hi  <= {c_out, sum[N-1:1]};
                    lo  <= {sum[0], lo[N-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
